// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between two writeback requesters, the arbiter, and the
// register file.
//   slave  : arbiter side (takes requests, drives readies and the write port)
//   master : requester / register-file side
// Signals:
//   reqN_valid/addr/data/ready : per-requester valid/ready write request
//   wr_en/wr_addr/wr_data      : registered register-file write port
//   init_done                  : zero sweep finished, requests accepted
//   stall_count                : saturating lost-arbitration counter
interface regfile_write_arbiter_if #(
  parameter int DEPTH = 32,
  parameter int BITS  = 64
);
  localparam int AW = $clog2(DEPTH);

  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [BITS-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [BITS-1:0] req1_data;
  logic            req1_ready;
  logic [AW-1:0]   wr_addr;
  logic [BITS-1:0] wr_data;
  logic            wr_en;
  logic            init_done;
  logic [15:0]     stall_count;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_addr, wr_data, wr_en, init_done, stall_count
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_addr, wr_data, wr_en, init_done, stall_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port owner. After reset it sweeps every register to
// zero, then round-robins the single write port between requester 0
// (execute writeback) and requester 1 (load return).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : regfile_write_arbiter_if.slave (requests, readies, write port,
//          init_done, stall_count)
module regfile_write_arbiter #(
  parameter int DEPTH = 32,
  parameter int BITS  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_write_arbiter_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SWEEP_END = (AW+1)'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [BITS-1:0] data;
  } wreq_t;

  state_t          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            ptr_q, ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [BITS-1:0] wr_data_q, wr_data_d;
  logic            init_done_q, init_done_d;
  logic [15:0]     stall_q, stall_d;

  logic  grant0, grant1, rdy0, rdy1, xfer, contend;
  wreq_t req0, req1, sel;

  assign req0 = '{addr: bus.req0_addr, data: bus.req0_data};
  assign req1 = '{addr: bus.req1_addr, data: bus.req1_data};

  // ptr=0 favours requester 0, ptr=1 favours requester 1; grants are exclusive
  assign contend = bus.req0_valid & bus.req1_valid;
  assign grant0  = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
  assign grant1  = bus.req1_valid & (~bus.req0_valid |  ptr_q);
  // init_done only rises with RUN; rst gates readies so nothing completes
  // in a reset cycle
  assign rdy0    = grant0 & init_done_q & ~rst;
  assign rdy1    = grant1 & init_done_q & ~rst;
  assign xfer    = rdy0 | rdy1;
  assign sel     = grant1 ? req1 : req0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;
    stall_d     = stall_q;
    case (state_q)
      INIT: begin
        if (cnt_q == SWEEP_END) begin
          init_done_d = 1'b1;
          state_d     = RUN;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[AW-1:0];
          wr_data_d = '0;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          wr_addr_d = sel.addr;
          wr_data_d = sel.data;
          // x0 is hardwired zero: consume the request, suppress the write
          wr_en_d   = (sel.addr != '0);
          ptr_d     = grant0;
        end
        if (contend && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.init_done   = init_done_q;
  assign bus.stall_count = stall_q;
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Owns the single write port of the register file and shares it between two writeback requesters: requester 0 is execute/ALU writeback and requester 1 is load return. After every reset it sweeps the register file to zero, then arbitrates round-robin with a valid/ready handshake per requester. It drives the register file's write address, data and enable from registered outputs. It also counts arbitration stalls for performance debug.

## Interface
Parameters:
- DEPTH, 32, number of registers in the register file; AW = $clog2(DEPTH)
- BITS, 64, register data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 (execute writeback) has a write pending
- req0_addr  in  AW  requester 0 destination register
- req0_data  in  BITS  requester 0 write data
- req0_ready  out  1  requester 0 write accepted this cycle
- req1_valid  in  1  requester 1 (load return) has a write pending
- req1_addr  in  AW  requester 1 destination register
- req1_data  in  BITS  requester 1 write data
- req1_ready  out  1  requester 1 write accepted this cycle
- wr_addr  out  AW  to register file write address
- wr_data  out  BITS  to register file write data
- wr_en  out  1  to register file write enable
- init_done  out  1  zero-sweep complete; arbiter accepting requests
- stall_count  out  16  saturating count of lost-arbitration cycles

## Operation
- State machine with two states, INIT and RUN, plus a sweep counter of AW+1 bits and a one-bit priority pointer (ptr).
- Reset (rst=1 at an edge) forces the following values:
  - state=INIT, counter=0, ptr=0 (requester 0 favoured)
  - wr_en=0, wr_addr=0, wr_data=0
  - init_done=0, stall_count=0
- INIT:
  - Each edge registers wr_en=1, wr_addr=counter, wr_data=0, then increments counter.
  - After address DEPTH-1 has been presented, the next edge sets wr_en=0, init_done=1 and state=RUN.
  - Both readies are 0 throughout INIT.
- RUN, grant is combinational:
  - Only one valid requester: that requester is granted.
  - Both valid: the requester selected by ptr is granted.
  - Neither valid: no grant.
- Ready: reqN_ready = grantN & init_done & !rst.
  - A transfer occurs on any cycle where valid and ready are both 1.
- On a transfer edge:
  - wr_addr and wr_data are loaded from the granted requester.
  - wr_en is loaded with (granted addr != 0).
  - A write to x0 is accepted and consumed, but never reaches the register file.
- On an edge with no transfer: wr_en=0, and wr_addr and wr_data hold their previous values.
- ptr update: after any transfer, ptr points to the requester that was not granted. This is strict alternation under contention.
- stall_count:
  - Increments on each RUN edge where both requesters are valid (exactly one loses).
  - Saturates at 16'hFFFF.
  - Never wraps.
- Requester rule: a requester holding valid=1 must keep addr and data stable until ready=1. The arbiter never drops a pending valid.

## Timing
- Write latency: a transfer in cycle N gives wr_en/wr_addr/wr_data valid in cycle N+1. The register file commits at the end of cycle N+1.
- Init length: edges 1..DEPTH after rst deassertion present addresses 0..DEPTH-1. Edge DEPTH+1 sets init_done=1, so the first transfer can occur in the cycle after that edge.
- Throughput: one write per cycle. Under continuous contention each requester gets every other cycle.
- Reset mid-operation:
  - rst=1 in any cycle forces both readies to 0 that cycle, so no transfer completes.
  - The next edge restarts INIT from address 0, even if a sweep or a write was in progress.
- Both requesters targeting the same address: the writes serialise in grant order, and the later grant wins in the register file.
- x0 traffic still toggles ptr and still counts toward stall_count.

## Test plan
- Reset then idle, DEPTH=32: wr_en=1 on edges 1..32 with wr_addr 0..31 and wr_data=0. init_done rises on edge 33. Readies are 0 until then.
- Single requester, req0 valid with addr=5, data=0xDEAD_BEEF: req0_ready=1 the same cycle. The next cycle shows wr_en=1, wr_addr=5, wr_data=0xDEADBEEF. stall_count stays 0.
- Both valid continuously for 6 cycles, req0 addr=1 and req1 addr=2: grants alternate 0,1,0,1,0,1 and stall_count=6.
- x0 write, req1 valid with addr=0, data=0xFF: req1_ready=1, the next cycle has wr_en=0, and ptr points to requester 0.
- Reset asserted while req0 is valid and init_done=1: req0_ready=0 that cycle and no write occurs. A full 32-entry sweep follows, after which req0 is accepted.
- Saturation: force 70000 contended cycles; stall_count holds at 16'hFFFF.
